// File: rtl/stream_pkg.sv
// Shared types for the stream packet buffer: write FSM states, descriptor layout and
// index-width helper.
package stream_pkg;

  // Descriptor field widths; they bound the id/qos/len widths a buffer instance may use.
  localparam int unsigned DescIdW  = 2;
  localparam int unsigned DescQosW = 4;
  localparam int unsigned DescLenW = 5;

  typedef enum logic [1:0] {
    StIdle,
    StFill,
    StDrop
  } wr_state_e;

  typedef struct packed {
    logic [DescIdW-1:0]  id;
    logic [DescQosW-1:0] qos;
    logic [DescLenW-1:0] len;
  } desc_t;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with registered occupancy count; the head entry is visible
// combinationally on rdata_o.
module sync_fifo
  import stream_pkg::*;
#(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 4,
  localparam int unsigned CntW = $clog2(Depth + 1),
  localparam int unsigned AW   = idx_width(Depth)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             pop_i,
  output logic [Width-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CntW-1:0]  count_o
);

  logic [Width-1:0] mem_q [Depth];
  logic [AW-1:0]    wr_idx_q, rd_idx_q;
  logic [CntW-1:0]  count_q;

  function automatic logic [AW-1:0] next_idx(input logic [AW-1:0] idx);
    return (idx == AW'(Depth - 1)) ? '0 : idx + AW'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (push_i) begin
      mem_q[wr_idx_q] <= wdata_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      wr_idx_q <= '0;
      rd_idx_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_idx_q <= next_idx(wr_idx_q);
      if (pop_i)  rd_idx_q <= next_idx(rd_idx_q);
      if (push_i && !pop_i)      count_q <= count_q + CntW'(1);
      else if (!push_i && pop_i) count_q <= count_q - CntW'(1);
    end
  end

  assign rdata_o = mem_q[rd_idx_q];
  assign full_o  = (count_q == CntW'(Depth));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

endmodule

// File: rtl/stream_packet_buffer.sv
// Store-and-forward packet buffer: a packet becomes visible downstream only once its last
// beat is stored; oversize packets are rewound and discarded with a drop pulse.
module stream_packet_buffer
  import stream_pkg::*;
#(
  parameter int unsigned T_DATA_WIDTH = 8,
  parameter int unsigned T_QOS__WIDTH = DescQosW,
  parameter int unsigned STREAM_COUNT = 3,
  parameter int unsigned T_ID___WIDTH = $clog2(STREAM_COUNT),
  parameter int unsigned DEPTH        = 16,
  parameter int unsigned MAX_PACKETS  = 4,
  localparam int unsigned LenW = $clog2(DEPTH + 1),
  localparam int unsigned CntW = $clog2(MAX_PACKETS + 1)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [T_DATA_WIDTH-1:0] s_data_i,
  input  logic [T_QOS__WIDTH-1:0] s_qos_i,
  input  logic [T_ID___WIDTH-1:0] s_id_i,
  input  logic                    s_last_i,
  input  logic                    s_valid_i,
  output logic                    s_ready_o,
  output logic [T_DATA_WIDTH-1:0] m_data_o,
  output logic [T_QOS__WIDTH-1:0] m_qos_o,
  output logic [T_ID___WIDTH-1:0] m_id_o,
  output logic [LenW-1:0]         m_len_o,
  output logic                    m_last_o,
  output logic                    m_valid_o,
  input  logic                    m_ready_i,
  output logic                    drop_o,
  output logic [CntW-1:0]         pkt_count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [T_DATA_WIDTH:0]   mem_q [DEPTH];
  wr_state_e               state_q, state_d;
  logic [PW-1:0]           wr_ptr_q, wr_ptr_d, commit_ptr_q, commit_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LenW-1:0]         pkt_len_q, pkt_len_d;
  logic [T_ID___WIDTH-1:0] id_q, id_d;
  logic [T_QOS__WIDTH-1:0] qos_q, qos_d;
  logic                    drop_q, drop_d;
  logic                    mem_we, accept, data_full, desc_full, desc_empty, oversize;
  logic                    desc_push, desc_pop, rd_fire;
  desc_t                   desc_in, desc_head;
  logic [T_DATA_WIDTH:0]   rd_entry;

  assign data_full = ((wr_ptr_q - rd_ptr_q) == PW'(DEPTH));
  assign oversize  = (state_q == StFill) && (pkt_len_q == LenW'(DEPTH));
  assign accept    = s_valid_i && s_ready_o;

  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    commit_ptr_d = commit_ptr_q;
    pkt_len_d    = pkt_len_q;
    id_d         = id_q;
    qos_d        = qos_q;
    drop_d       = 1'b0;
    mem_we       = 1'b0;
    desc_push    = 1'b0;
    desc_in      = '0;
    s_ready_o    = !data_full && !desc_full;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          mem_we    = 1'b1;
          wr_ptr_d  = wr_ptr_q + PW'(1);
          id_d      = s_id_i;
          qos_d     = s_qos_i;
          pkt_len_d = LenW'(1);
          if (s_last_i) begin
            desc_push    = 1'b1;
            desc_in.id   = DescIdW'(s_id_i);
            desc_in.qos  = DescQosW'(s_qos_i);
            desc_in.len  = DescLenW'(1);
            commit_ptr_d = wr_ptr_q + PW'(1);
          end else begin
            state_d = StFill;
          end
        end
      end
      StFill: begin
        // The beat that would overflow is taken even when storage is full so it can be discarded.
        if (oversize) s_ready_o = 1'b1;
        if (accept) begin
          if (oversize) begin
            wr_ptr_d = commit_ptr_q;
            if (s_last_i) begin
              drop_d  = 1'b1;
              state_d = StIdle;
            end else begin
              state_d = StDrop;
            end
          end else begin
            mem_we    = 1'b1;
            wr_ptr_d  = wr_ptr_q + PW'(1);
            pkt_len_d = pkt_len_q + LenW'(1);
            if (s_last_i) begin
              desc_push    = 1'b1;
              desc_in.id   = DescIdW'(id_q);
              desc_in.qos  = DescQosW'(qos_q);
              desc_in.len  = DescLenW'(pkt_len_q + LenW'(1));
              commit_ptr_d = wr_ptr_q + PW'(1);
              state_d      = StIdle;
            end
          end
        end
      end
      StDrop: begin
        s_ready_o = 1'b1;
        if (accept && s_last_i) begin
          drop_d  = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[wr_ptr_q[AW-1:0]] <= {s_data_i, s_last_i};
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q      <= StIdle;
      wr_ptr_q     <= '0;
      commit_ptr_q <= '0;
      rd_ptr_q     <= '0;
      pkt_len_q    <= '0;
      id_q         <= '0;
      qos_q        <= '0;
      drop_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      commit_ptr_q <= commit_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      pkt_len_q    <= pkt_len_d;
      id_q         <= id_d;
      qos_q        <= qos_d;
      drop_q       <= drop_d;
    end
  end

  // A descriptor exists only for fully committed packets, so reads never pass commit_ptr.
  assign rd_entry  = mem_q[rd_ptr_q[AW-1:0]];
  assign m_valid_o = !desc_empty;
  assign rd_fire   = m_valid_o && m_ready_i;
  assign desc_pop  = rd_fire && rd_entry[0];
  assign rd_ptr_d  = rd_fire ? rd_ptr_q + PW'(1) : rd_ptr_q;

  assign m_data_o = rd_entry[T_DATA_WIDTH:1];
  assign m_last_o = m_valid_o && rd_entry[0];
  assign m_id_o   = desc_head.id[T_ID___WIDTH-1:0];
  assign m_qos_o  = desc_head.qos[T_QOS__WIDTH-1:0];
  assign m_len_o  = desc_head.len[LenW-1:0];
  assign drop_o   = drop_q;

  sync_fifo #(
    .Width ($bits(desc_t)),
    .Depth (MAX_PACKETS)
  ) u_desc_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (desc_push),
    .wdata_i (desc_in),
    .pop_i   (desc_pop),
    .rdata_o (desc_head),
    .full_o  (desc_full),
    .empty_o (desc_empty),
    .count_o (pkt_count_o)
  );

endmodule

// File: tb/tb_stream_packet_buffer.sv
// Scoreboard bench for stream_packet_buffer: expected beats are queued as packets are driven
// and checked as they handshake out.
module tb_stream_packet_buffer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] s_data_i;
  logic [3:0] s_qos_i;
  logic [1:0] s_id_i;
  logic       s_last_i;
  logic       s_valid_i;
  logic       s_ready_o;
  logic [7:0] m_data_o;
  logic [3:0] m_qos_o;
  logic [1:0] m_id_o;
  logic [4:0] m_len_o;
  logic       m_last_o;
  logic       m_valid_o;
  logic       m_ready_i;
  logic       drop_o;
  logic [2:0] pkt_count_o;

  typedef struct packed {
    logic [7:0] data;
    logic [1:0] id;
    logic [3:0] qos;
    logic [4:0] len;
    logic       last;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   vectors = 0;
  int   errors  = 0;
  int   drop_cnt = 0;
  int   acc_cnt  = 0;

  stream_packet_buffer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .s_data_i    (s_data_i),
    .s_qos_i     (s_qos_i),
    .s_id_i      (s_id_i),
    .s_last_i    (s_last_i),
    .s_valid_i   (s_valid_i),
    .s_ready_o   (s_ready_o),
    .m_data_o    (m_data_o),
    .m_qos_o     (m_qos_o),
    .m_id_o      (m_id_o),
    .m_len_o     (m_len_o),
    .m_last_o    (m_last_o),
    .m_valid_o   (m_valid_o),
    .m_ready_i   (m_ready_i),
    .drop_o      (drop_o),
    .pkt_count_o (pkt_count_o)
  );

  always #5 clk = ~clk;

  // Output scoreboard: every downstream handshake pops and checks one expected beat.
  always @(negedge clk) begin
    if (!rst_n && m_valid_o && m_ready_i) begin
      vectors++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL out_beat: unexpected beat data=%h id=%0d, required none", m_data_o, m_id_o);
      end else begin
        mon_e = exp_q.pop_front();
        if ({m_data_o, m_id_o, m_qos_o, m_len_o, m_last_o} !== mon_e) begin
          errors++;
          $display("FAIL out_beat: got d=%h id=%0d q=%0d len=%0d last=%0b, required d=%h id=%0d q=%0d len=%0d last=%0b",
                   m_data_o, m_id_o, m_qos_o, m_len_o, m_last_o,
                   mon_e.data, mon_e.id, mon_e.qos, mon_e.len, mon_e.last);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (drop_o) drop_cnt++;
    if (s_valid_i && s_ready_o) acc_cnt++;
  end

  task automatic expect_beat(input logic [7:0] d, input logic [1:0] id, input logic [3:0] q,
                             input logic [4:0] len, input logic last);
    exp_t e;
    e = '{data: d, id: id, qos: q, len: len, last: last};
    exp_q.push_back(e);
  endtask

  // Drives one beat from posedge+1 and returns at posedge+1 after it is accepted.
  task automatic send_beat(input logic [7:0] d, input logic [1:0] id, input logic [3:0] q,
                           input logic last);
    int guard = 0;
    s_data_i  = d;
    s_id_i    = id;
    s_qos_i   = q;
    s_last_i  = last;
    s_valid_i = 1'b1;
    @(negedge clk);
    while (!s_ready_o && guard < 200) begin
      guard++;
      @(negedge clk);
    end
    if (guard >= 200) begin
      vectors++;
      errors++;
      $display("FAIL send_timeout: beat %h never accepted, s_ready_o=%0b required 1", d, s_ready_o);
    end
    @(posedge clk);
    #1;
    s_valid_i = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int guard = 0;
    while (exp_q.size() != 0 && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    vectors++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: %0d beats outstanding, required 0", name, exp_q.size());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(negedge clk);
    vectors += 5;
    if (m_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b required 0", m_valid_o); end
    if (m_last_o !== 1'b0) begin errors++; $display("FAIL reset_last: got %0b required 0", m_last_o); end
    if (drop_o !== 1'b0) begin errors++; $display("FAIL reset_drop: got %0b required 0", drop_o); end
    if (pkt_count_o !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d required 0", pkt_count_o); end
    if (s_ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready: got %0b required 1", s_ready_o); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_single();
    m_ready_i = 1'b1;
    expect_beat(8'hA5, 2'd2, 4'd6, 5'd1, 1'b1);
    send_beat(8'hA5, 2'd2, 4'd6, 1'b1);
    vectors += 2;
    if (m_valid_o !== 1'b1) begin errors++; $display("FAIL single_latency: valid=%0b required 1", m_valid_o); end
    if (m_len_o !== 5'd1) begin errors++; $display("FAIL single_len: got %0d required 1", m_len_o); end
    wait_drain("single");
  endtask

  task automatic test_multi_beat();
    m_ready_i = 1'b1;
    expect_beat(8'h11, 2'd1, 4'd3, 5'd3, 1'b0);
    expect_beat(8'h22, 2'd1, 4'd3, 5'd3, 1'b0);
    expect_beat(8'h33, 2'd1, 4'd3, 5'd3, 1'b1);
    send_beat(8'h11, 2'd1, 4'd3, 1'b0);
    vectors++;
    if (m_valid_o !== 1'b0) begin errors++; $display("FAIL multi_early1: valid=%0b required 0", m_valid_o); end
    send_beat(8'h22, 2'd0, 4'd9, 1'b0);
    vectors++;
    if (m_valid_o !== 1'b0) begin errors++; $display("FAIL multi_early2: valid=%0b required 0", m_valid_o); end
    send_beat(8'h33, 2'd2, 4'd7, 1'b1);
    vectors++;
    if (m_valid_o !== 1'b1) begin errors++; $display("FAIL multi_commit: valid=%0b required 1", m_valid_o); end
    wait_drain("multi");
  endtask

  task automatic test_backpressure();
    m_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      expect_beat(8'h40 + 8'(i), 2'(i % 3), 4'(i + 1), 5'd1, 1'b1);
      send_beat(8'h40 + 8'(i), 2'(i % 3), 4'(i + 1), 1'b1);
    end
    @(negedge clk);
    vectors += 3;
    if (pkt_count_o !== 3'd4) begin errors++; $display("FAIL bp_count: got %0d required 4", pkt_count_o); end
    if (s_ready_o !== 1'b0) begin errors++; $display("FAIL bp_ready: got %0b required 0", s_ready_o); end
    if (m_data_o !== 8'h40) begin errors++; $display("FAIL bp_head: got %h required 40", m_data_o); end
    @(posedge clk);
    #1;
    m_ready_i = 1'b1;
    wait_drain("backpressure");
  endtask

  task automatic test_oversize();
    int drop_base;
    int acc_base;
    m_ready_i = 1'b1;
    drop_base = drop_cnt;
    acc_base  = acc_cnt;
    for (int i = 0; i < 17; i++) begin
      send_beat(8'h80 + 8'(i), 2'd1, 4'd3, (i == 16));
    end
    repeat (3) @(negedge clk);
    vectors += 3;
    if (acc_cnt - acc_base !== 17) begin
      errors++; $display("FAIL oversize_accept: got %0d beats required 17", acc_cnt - acc_base);
    end
    if (drop_cnt - drop_base !== 1) begin
      errors++; $display("FAIL oversize_drop: got %0d pulses required 1", drop_cnt - drop_base);
    end
    if (pkt_count_o !== 3'd0) begin errors++; $display("FAIL oversize_count: got %0d required 0", pkt_count_o); end
    @(posedge clk);
    #1;
    expect_beat(8'hC1, 2'd2, 4'd5, 5'd2, 1'b0);
    expect_beat(8'hC2, 2'd2, 4'd5, 5'd2, 1'b1);
    send_beat(8'hC1, 2'd2, 4'd5, 1'b0);
    send_beat(8'hC2, 2'd2, 4'd5, 1'b1);
    wait_drain("after_drop");
  endtask

  task automatic test_back_to_back();
    m_ready_i = 1'b0;
    expect_beat(8'hA1, 2'd0, 4'd1, 5'd2, 1'b0);
    expect_beat(8'hA2, 2'd0, 4'd1, 5'd2, 1'b1);
    expect_beat(8'hB1, 2'd1, 4'd2, 5'd2, 1'b0);
    expect_beat(8'hB2, 2'd1, 4'd2, 5'd2, 1'b1);
    send_beat(8'hA1, 2'd0, 4'd1, 1'b0);
    send_beat(8'hA2, 2'd0, 4'd1, 1'b1);
    send_beat(8'hB1, 2'd1, 4'd2, 1'b0);
    // A0 handshakes at the next edge; B's last and A's last then share the edge after.
    m_ready_i = 1'b1;
    @(posedge clk);
    #1;
    s_data_i  = 8'hB2;
    s_id_i    = 2'd1;
    s_qos_i   = 4'd2;
    s_last_i  = 1'b1;
    s_valid_i = 1'b1;
    @(negedge clk);
    vectors++;
    if (s_ready_o !== 1'b1) begin errors++; $display("FAIL b2b_ready: got %0b required 1", s_ready_o); end
    @(posedge clk);
    #1;
    s_valid_i = 1'b0;
    vectors += 3;
    if (pkt_count_o !== 3'd1) begin errors++; $display("FAIL b2b_count: got %0d required 1", pkt_count_o); end
    if (m_valid_o !== 1'b1) begin errors++; $display("FAIL b2b_bubble: valid=%0b required 1", m_valid_o); end
    if (m_data_o !== 8'hB1) begin errors++; $display("FAIL b2b_head: got %h required B1", m_data_o); end
    wait_drain("back_to_back");
  endtask

  task automatic test_mid_reset();
    m_ready_i = 1'b0;
    expect_beat(8'h61, 2'd0, 4'd4, 5'd1, 1'b1);
    send_beat(8'h61, 2'd0, 4'd4, 1'b1);
    send_beat(8'h71, 2'd2, 4'd8, 1'b0);
    send_beat(8'h72, 2'd2, 4'd8, 1'b0);
    rst_n = 1'b1;
    exp_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    vectors += 3;
    if (m_valid_o !== 1'b0) begin errors++; $display("FAIL midrst_valid: got %0b required 0", m_valid_o); end
    if (pkt_count_o !== 3'd0) begin errors++; $display("FAIL midrst_count: got %0d required 0", pkt_count_o); end
    if (s_ready_o !== 1'b1) begin errors++; $display("FAIL midrst_ready: got %0b required 1", s_ready_o); end
    m_ready_i = 1'b1;
    expect_beat(8'h5A, 2'd1, 4'd15, 5'd1, 1'b1);
    send_beat(8'h5A, 2'd1, 4'd15, 1'b1);
    wait_drain("after_reset");
  endtask

  initial begin
    rst_n     = 1'b1;
    s_data_i  = '0;
    s_qos_i   = '0;
    s_id_i    = '0;
    s_last_i  = 1'b0;
    s_valid_i = 1'b0;
    m_ready_i = 1'b0;
    test_reset();
    test_single();
    test_multi_beat();
    test_backpressure();
    test_oversize();
    test_back_to_back();
    test_mid_reset();
    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
